// File: rtl/lt24_hires_key_pio_in_pkg.sv
// Shared constants for the LT24 hires input PIO: register map, edge selection
// and the debounce counter sizing helper.
package lt24_hires_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Counter must hold 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lt24_hires_key_pio_in_if.sv
// Avalon-MM slave bus plus interrupt line of the key input PIO.
interface lt24_hires_key_pio_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/lt24_hires_debounce_bit.sv
// One key input: two-flop synchronizer, hold-time debounce counter, debounced
// level flop and a combinational pulse on the edge that updates the level.
module lt24_hires_debounce_bit
  import lt24_hires_pio_pkg::*;
#(
  parameter logic RESET_VALUE     = 1'b1,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   EDGE_TYPE       = EDGE_FALLING
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic deb,
  output logic edge_event
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             deb_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             accept;

  // New level has been seen on every compare for DEBOUNCE_CYCLES clocks.
  assign accept = (s2_reg != deb_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg  <= RESET_VALUE;
      s2_reg  <= RESET_VALUE;
      deb_reg <= RESET_VALUE;
      cnt_reg <= '0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
      if (s2_reg == deb_reg) begin
        cnt_reg <= '0;
      end else if (accept) begin
        deb_reg <= s2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    edge_event = 1'b0;
    if (accept) begin
      if (EDGE_TYPE == EDGE_RISING)
        edge_event = s2_reg;
      else if (EDGE_TYPE == EDGE_FALLING)
        edge_event = ~s2_reg;
      else
        edge_event = 1'b1;
    end
  end

  assign deb = deb_reg;

endmodule

// File: rtl/lt24_hires_key_pio_in.sv
// Avalon-MM input PIO for the active-low KEY buttons: debounced data register,
// write-1-to-clear edge capture, per-bit IRQ mask and level interrupt.
module lt24_hires_key_pio_in
  import lt24_hires_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}},
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               EDGE_TYPE       = EDGE_FALLING
) (
  input  logic                     clk,
  input  logic                     reset,
  lt24_hires_key_pio_in_if.slave   bus,
  input  logic [WIDTH-1:0]         in_port
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edgecap_next;
  logic             wr_en;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      lt24_hires_debounce_bit #(
        .RESET_VALUE     (RESET_VALUE[gi]),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .EDGE_TYPE       (EDGE_TYPE)
      ) u_deb (
        .clk        (clk),
        .reset      (reset),
        .din        (in_port[gi]),
        .deb        (deb[gi]),
        .edge_event (edge_event[gi])
      );
    end
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  assign wr_en = bus.chipselect & ~bus.write_n;

  // Clear first, then OR in new edges so a coincident edge survives the clear.
  always_comb begin
    edgecap_next = edgecap_reg;
    if (wr_en && (bus.address == PIO_ADDR_EDGECAP))
      edgecap_next = edgecap_reg & ~bus.writedata[WIDTH-1:0];
    edgecap_next = edgecap_next | edge_event;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_reg    <= '0;
      edgecap_reg <= '0;
    end else begin
      if (wr_en && (bus.address == PIO_ADDR_IRQMASK))
        mask_reg <= bus.writedata[WIDTH-1:0];
      edgecap_reg <= edgecap_next;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      PIO_ADDR_DATA:    bus.readdata[WIDTH-1:0] = deb;
      PIO_ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = mask_reg;
      PIO_ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edgecap_reg;
      default:          bus.readdata = '0;
    endcase
  end

  assign bus.irq = |(edgecap_reg & mask_reg);

endmodule

// File: tb/tb_lt24_hires_key_pio_in.sv
// Directed bench for the key input PIO: falling-edge instance plus an
// any-edge instance sharing clock and reset.
module tb_lt24_hires_key_pio_in;

  logic       clk;
  logic       reset;
  logic [3:0] in_port1;
  logic [3:0] in_port2;
  int         vectors;
  int         miscompares;

  lt24_hires_key_pio_in_if bus1 ();
  lt24_hires_key_pio_in_if bus2 ();

  lt24_hires_key_pio_in #(
    .WIDTH(4), .RESET_VALUE(4'hF), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port1)
  );

  lt24_hires_key_pio_in #(
    .WIDTH(4), .RESET_VALUE(4'hF), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr1(input logic [1:0] a, input logic [31:0] d);
    bus1.address = a; bus1.writedata = d; bus1.chipselect = 1'b1; bus1.write_n = 1'b0;
    step(1);
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
  endtask

  task automatic wr2(input logic [1:0] a, input logic [31:0] d);
    bus2.address = a; bus2.writedata = d; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
    step(1);
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_port1 = 4'hF; in_port2 = 4'hF;
    step(3);
    reset = 1'b0;
    step(1);
    bus1.address = 2'd0; #1;
    vectors++;
    if (bus1.readdata !== 32'h0000000F) begin
      miscompares++; $display("FAIL reset_data got %h exp %h", bus1.readdata, 32'h0000000F);
    end
    bus1.address = 2'd2; #1;
    vectors++;
    if (bus1.readdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_mask got %h exp %h", bus1.readdata, 32'h0);
    end
    bus1.address = 2'd3; #1;
    vectors++;
    if (bus1.readdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_edgecap got %h exp %h", bus1.readdata, 32'h0);
    end
    vectors++;
    if (bus1.irq !== 1'b0) begin
      miscompares++; $display("FAIL reset_irq got %b exp 0", bus1.irq);
    end
    $display("reset: data/mask/edgecap/irq checked");
  endtask

  task automatic test_latency;
    in_port1 = 4'hE;
    bus1.address = 2'd0;
    step(5);
    vectors++;
    if (bus1.readdata !== 32'hF) begin
      miscompares++; $display("FAIL lat_k4 got %h exp %h", bus1.readdata, 32'hF);
    end
    step(1);
    vectors++;
    if (bus1.readdata !== 32'hE) begin
      miscompares++; $display("FAIL lat_k5 got %h exp %h", bus1.readdata, 32'hE);
    end
    bus1.address = 2'd3; #1;
    vectors++;
    if (bus1.readdata !== 32'h1) begin
      miscompares++; $display("FAIL lat_edgecap got %h exp %h", bus1.readdata, 32'h1);
    end
    vectors++;
    if (bus1.irq !== 1'b0) begin
      miscompares++; $display("FAIL lat_irq_masked got %b exp 0", bus1.irq);
    end
    wr1(2'd2, 32'h1);
    vectors++;
    if (bus1.irq !== 1'b1) begin
      miscompares++; $display("FAIL lat_irq_unmasked got %b exp 1", bus1.irq);
    end
    bus1.address = 2'd2; #1;
    vectors++;
    if (bus1.readdata !== 32'h1) begin
      miscompares++; $display("FAIL lat_mask_rd got %h exp %h", bus1.readdata, 32'h1);
    end
    $display("latency: deb at k+5, edgecap and irq masking checked");
  endtask

  task automatic test_glitch;
    in_port1 = 4'hC;
    step(3);
    in_port1 = 4'hE;
    step(10);
    bus1.address = 2'd0; #1;
    vectors++;
    if (bus1.readdata !== 32'hE) begin
      miscompares++; $display("FAIL glitch_data got %h exp %h", bus1.readdata, 32'hE);
    end
    bus1.address = 2'd3; #1;
    vectors++;
    if (bus1.readdata !== 32'h1) begin
      miscompares++; $display("FAIL glitch_edgecap got %h exp %h", bus1.readdata, 32'h1);
    end
    in_port1 = 4'hC;
    step(10);
    bus1.address = 2'd0; #1;
    vectors++;
    if (bus1.readdata !== 32'hC) begin
      miscompares++; $display("FAIL hold_data got %h exp %h", bus1.readdata, 32'hC);
    end
    bus1.address = 2'd3; #1;
    vectors++;
    if (bus1.readdata !== 32'h3) begin
      miscompares++; $display("FAIL hold_edgecap got %h exp %h", bus1.readdata, 32'h3);
    end
    $display("glitch: 3-cycle pulse rejected, long hold accepted");
  endtask

  task automatic test_clear;
    wr1(2'd3, 32'h1);
    bus1.address = 2'd3; #1;
    vectors++;
    if (bus1.readdata !== 32'h2) begin
      miscompares++; $display("FAIL clear_bit0 got %h exp %h", bus1.readdata, 32'h2);
    end
    vectors++;
    if (bus1.irq !== 1'b0) begin
      miscompares++; $display("FAIL clear_irq got %b exp 0", bus1.irq);
    end
    in_port1 = 4'hE;
    step(8);
    bus1.address = 2'd0; #1;
    vectors++;
    if (bus1.readdata !== 32'hE) begin
      miscompares++; $display("FAIL release_data got %h exp %h", bus1.readdata, 32'hE);
    end
    // New bit-1 falling edge lands on edge k+5, same edge as the clear write.
    in_port1 = 4'hC;
    step(5);
    wr1(2'd3, 32'h2);
    bus1.address = 2'd3; #1;
    vectors++;
    if (bus1.readdata !== 32'h2) begin
      miscompares++; $display("FAIL set_wins got %h exp %h", bus1.readdata, 32'h2);
    end
    bus1.address = 2'd0; #1;
    vectors++;
    if (bus1.readdata !== 32'hC) begin
      miscompares++; $display("FAIL set_wins_data got %h exp %h", bus1.readdata, 32'hC);
    end
    wr1(2'd3, 32'h2);
    bus1.address = 2'd3; #1;
    vectors++;
    if (bus1.readdata !== 32'h0) begin
      miscompares++; $display("FAIL clear_bit1 got %h exp %h", bus1.readdata, 32'h0);
    end
    $display("clear: w1c per bit and set-wins checked");
  endtask

  task automatic test_rising;
    in_port1 = 4'hD;
    step(8);
    bus1.address = 2'd0; #1;
    vectors++;
    if (bus1.readdata !== 32'hD) begin
      miscompares++; $display("FAIL rise_data got %h exp %h", bus1.readdata, 32'hD);
    end
    bus1.address = 2'd3; #1;
    vectors++;
    if (bus1.readdata !== 32'h0) begin
      miscompares++; $display("FAIL rise_edgecap got %h exp %h", bus1.readdata, 32'h0);
    end
    $display("rising: ignored with falling edge type");
  endtask

  task automatic test_edge_any;
    in_port2 = 4'hE;
    step(8);
    bus2.address = 2'd3; #1;
    vectors++;
    if (bus2.readdata !== 32'h1) begin
      miscompares++; $display("FAIL any_fall got %h exp %h", bus2.readdata, 32'h1);
    end
    wr2(2'd3, 32'h1);
    bus2.address = 2'd3; #1;
    vectors++;
    if (bus2.readdata !== 32'h0) begin
      miscompares++; $display("FAIL any_clear got %h exp %h", bus2.readdata, 32'h0);
    end
    in_port2 = 4'hF;
    step(8);
    bus2.address = 2'd3; #1;
    vectors++;
    if (bus2.readdata !== 32'h1) begin
      miscompares++; $display("FAIL any_rise got %h exp %h", bus2.readdata, 32'h1);
    end
    wr2(2'd2, 32'h1);
    vectors++;
    if (bus2.irq !== 1'b1) begin
      miscompares++; $display("FAIL any_irq got %b exp 1", bus2.irq);
    end
    $display("edge_any: both edges captured");
  endtask

  task automatic test_async_reset;
    in_port1 = 4'hC;
    step(4);
    bus1.address = 2'd0;
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus1.readdata !== 32'hF) begin
      miscompares++; $display("FAIL arst_data got %h exp %h", bus1.readdata, 32'hF);
    end
    vectors++;
    if (bus2.irq !== 1'b0) begin
      miscompares++; $display("FAIL arst_irq got %b exp 0", bus2.irq);
    end
    bus1.address = 2'd2; #1;
    vectors++;
    if (bus1.readdata !== 32'h0) begin
      miscompares++; $display("FAIL arst_mask got %h exp %h", bus1.readdata, 32'h0);
    end
    in_port1 = 4'hE;
    step(2);
    reset = 1'b0;
    bus1.address = 2'd3;
    step(5);
    vectors++;
    if (bus1.readdata !== 32'h0) begin
      miscompares++; $display("FAIL arst_ec_early got %h exp %h", bus1.readdata, 32'h0);
    end
    step(1);
    vectors++;
    if (bus1.readdata !== 32'h1) begin
      miscompares++; $display("FAIL arst_ec_k5 got %h exp %h", bus1.readdata, 32'h1);
    end
    bus1.address = 2'd0; #1;
    vectors++;
    if (bus1.readdata !== 32'hE) begin
      miscompares++; $display("FAIL arst_data_post got %h exp %h", bus1.readdata, 32'hE);
    end
    $display("async_reset: mid-debounce reset and held-key report checked");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    bus1.address = 2'd0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
    bus2.address = 2'd0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
    test_reset;
    test_latency;
    test_glitch;
    test_clear;
    test_rising;
    test_edge_any;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
